// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM: byte-lane writes on port A, 1-cycle registered reads on port B.
// Define BRAM_RAW_FWD_EN to forward write data on a same-word read-after-write instead of inserting a wait state.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  typedef enum logic [1:0] {IDLE, DPHASE, STALL} state_t;

  state_t                  state_q, state_next;
  logic                    acc;
  logic [ADDR_WIDTH-1:0]   haddr_word;
  logic [3:0]              lanes;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              lanes_q;
  logic                    write_q;
  logic                    rd_q;
  logic                    haz_q;
  logic                    wr_dphase;
  logic                    haz_now;
  logic                    stall_now;
  logic [31:0]             rd_data;
  logic                    unused_ok;

  assign acc        = HSEL & HTRANS[1] & HREADY;
  assign haddr_word = HADDR[ADDR_WIDTH+1:2];
  assign unused_ok  = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  always_comb begin
    case (HSIZE)
      3'd0:    lanes = 4'b0001 << HADDR[1:0];
      3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  assign wr_dphase = (state_q == DPHASE) & write_q;
  // A read address phase landing on the word being written this cycle sees the pre-write RAM contents.
  assign haz_now   = wr_dphase & ~HWRITE & (haddr_word == addr_q);

`ifdef BRAM_RAW_FWD_EN
  logic [3:0]  wl_q;
  logic [31:0] wd_q;

  assign stall_now = 1'b0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign rd_data[8*gi +: 8] = (haz_q & wl_q[gi]) ? wd_q[8*gi +: 8] : doutb[8*gi +: 8];
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      wl_q <= 4'b0000;
      wd_q <= 32'h0;
    end else if (acc) begin
      wl_q <= lanes_q;
      wd_q <= HWDATA;
    end
  end
`else
  assign stall_now = (state_q == DPHASE) & rd_q & haz_q;
  assign rd_data   = doutb;
`endif

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lanes_q <= 4'b0000;
      write_q <= 1'b0;
      rd_q    <= 1'b0;
      haz_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      if (HREADY) begin
        write_q <= acc & HWRITE;
        rd_q    <= acc & ~HWRITE;
        haz_q   <= acc & haz_now;
        if (acc) begin
          addr_q  <= haddr_word;
          lanes_q <= lanes;
        end
      end
    end
  end

  always_comb begin
    state_next = state_q;
    HRDATA     = 32'h0;
    case (state_q)
      IDLE: begin
        if (acc) state_next = DPHASE;
      end
      DPHASE: begin
        if (rd_q) HRDATA = rd_data;
        if (stall_now)   state_next = STALL;
        else if (HREADY) state_next = acc ? DPHASE : IDLE;
      end
      STALL: begin
        if (rd_q) HRDATA = doutb;
        state_next = acc ? DPHASE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The stall cycle re-reads the hazard word so STALL gets the post-write value.
  assign addrb     = stall_now ? addr_q : haddr_word;
  assign HREADYOUT = ~stall_now;
  assign HRESP     = 1'b0;
  assign addra     = addr_q;
  assign dina      = HWDATA;
  // Gating with rsta drops a write whose data phase overlaps reset.
  assign wea       = (wr_dphase & ~rsta) ? lanes_q : 4'b0000;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural read-first block RAM on ports A/B.
module tb_ahb_bram_ctrl;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rsta;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb;

  logic [31:0] mem [0:(1<<AW)-1];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign HREADY = HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clka(clk), .rsta(rsta), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  always @(posedge clk) begin
    doutb <= mem[addrb];
    for (int i = 0; i < 4; i++)
      if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0;
  endtask

  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HADDR = addr;
  endtask

  task automatic test_reset();
    rsta = 1'b1; bus_idle(); HWDATA = 32'h0;
    tick(); tick();
    rsta = 1'b0;
    settle();
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL rst_hreadyout got %b exp 1", HREADYOUT); else n_pass++;
    n_checks++; if (wea !== 4'h0) $display("FAIL rst_wea got %h exp 0", wea); else n_pass++;
    n_checks++; if (HRESP !== 1'b0) $display("FAIL rst_hresp got %b exp 0", HRESP); else n_pass++;
    n_checks++; if (HRDATA !== 32'h0) $display("FAIL rst_hrdata got %h exp 0", HRDATA); else n_pass++;
    $display("reset: hreadyout=%b wea=%h hrdata=%h", HREADYOUT, wea, HRDATA);
  endtask

  task automatic test_unselected();
    tick(); bus_xfer(1'b1, 32'h100, 3'd2); HSEL = 1'b0;
    tick(); bus_idle(); HWDATA = 32'h12345678; settle();
    n_checks++; if (wea !== 4'h0) $display("FAIL unsel_wea got %h exp 0", wea); else n_pass++;
    bus_xfer(1'b1, 32'h100, 3'd2); HTRANS = 2'b01;
    tick(); bus_idle(); settle();
    n_checks++; if (wea !== 4'h0) $display("FAIL busy_wea got %h exp 0", wea); else n_pass++;
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL busy_hreadyout got %b exp 1", HREADYOUT); else n_pass++;
    $display("unselected/busy: wea=%h", wea);
  endtask

  task automatic test_word_rw();
    tick(); bus_xfer(1'b1, 32'h100, 3'd2);
    tick(); bus_idle(); HWDATA = 32'hDEADBEEF; settle();
    n_checks++; if (wea !== 4'hF) $display("FAIL word_wea got %h exp f", wea); else n_pass++;
    n_checks++; if (addra !== 14'h40) $display("FAIL word_addra got %h exp 40", addra); else n_pass++;
    n_checks++; if (dina !== 32'hDEADBEEF) $display("FAIL word_dina got %h exp deadbeef", dina); else n_pass++;
    tick(); bus_xfer(1'b0, 32'h100, 3'd2); settle();
    n_checks++; if (addrb !== 14'h40) $display("FAIL word_addrb got %h exp 40", addrb); else n_pass++;
    tick(); bus_idle(); settle();
    n_checks++; if (HRDATA !== 32'hDEADBEEF) $display("FAIL word_hrdata got %h exp deadbeef", HRDATA); else n_pass++;
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL word_hreadyout got %b exp 1", HREADYOUT); else n_pass++;
    $display("word write/read 0x100: hrdata=%h", HRDATA);
  endtask

  task automatic test_byte_half();
    tick(); bus_xfer(1'b1, 32'h103, 3'd0);
    tick(); bus_xfer(1'b1, 32'h100, 3'd1); HWDATA = 32'h12000000; settle();
    n_checks++; if (wea !== 4'h8) $display("FAIL byte_wea got %h exp 8", wea); else n_pass++;
    tick(); bus_idle(); HWDATA = 32'h00003456; settle();
    n_checks++; if (wea !== 4'h3) $display("FAIL half_wea got %h exp 3", wea); else n_pass++;
    tick(); bus_xfer(1'b0, 32'h100, 3'd2);
    tick(); bus_idle(); settle();
    n_checks++; if (HRDATA !== 32'h12AD3456) $display("FAIL bh_hrdata got %h exp 12ad3456", HRDATA); else n_pass++;
    $display("byte+half write, read 0x100: hrdata=%h", HRDATA);
  endtask

  task automatic hazard_seq(input logic [2:0] size, input logic [31:0] waddr,
                            input logic [31:0] wdata, input logic [31:0] expv, input string nm);
    tick(); bus_xfer(1'b1, waddr, size);
    tick(); bus_xfer(1'b0, 32'h200, 3'd2); HWDATA = wdata;
    tick(); bus_idle(); settle();
`ifdef BRAM_RAW_FWD_EN
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL %s_nostall got %b exp 1", nm, HREADYOUT); else n_pass++;
    n_checks++; if (HRDATA !== expv) $display("FAIL %s_hrdata got %h exp %h", nm, HRDATA, expv); else n_pass++;
`else
    n_checks++; if (HREADYOUT !== 1'b0) $display("FAIL %s_stall got %b exp 0", nm, HREADYOUT); else n_pass++;
    n_checks++; if (addrb !== 14'h80) $display("FAIL %s_reread_addrb got %h exp 80", nm, addrb); else n_pass++;
    tick(); settle();
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL %s_after_stall got %b exp 1", nm, HREADYOUT); else n_pass++;
    n_checks++; if (HRDATA !== expv) $display("FAIL %s_hrdata got %h exp %h", nm, HRDATA, expv); else n_pass++;
`endif
    $display("hazard %s: hrdata=%h", nm, HRDATA);
  endtask

  task automatic test_hazard();
    hazard_seq(3'd2, 32'h200, 32'h11223344, 32'h11223344, "haz_word");
    hazard_seq(3'd0, 32'h201, 32'h0000AA00, 32'h1122AA44, "haz_byte");
  endtask

  task automatic test_diff_word();
    tick(); bus_xfer(1'b1, 32'h300, 3'd2);
    tick(); bus_xfer(1'b0, 32'h304, 3'd2); HWDATA = 32'h55555555; settle();
    n_checks++; if (wea !== 4'hF) $display("FAIL dw_wea got %h exp f", wea); else n_pass++;
    tick(); bus_idle(); settle();
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL dw_nostall got %b exp 1", HREADYOUT); else n_pass++;
    n_checks++; if (HRDATA !== 32'hCAFEF00D) $display("FAIL dw_hrdata got %h exp cafef00d", HRDATA); else n_pass++;
    $display("write 0x300 / read 0x304: hrdata=%h", HRDATA);
  endtask

  task automatic test_back_to_back();
    tick(); bus_xfer(1'b0, 32'h100, 3'd2);
    tick(); bus_xfer(1'b0, 32'h200, 3'd2); settle();
    n_checks++; if (HRDATA !== 32'h12AD3456) $display("FAIL b2b_rd1 got %h exp 12ad3456", HRDATA); else n_pass++;
    tick(); bus_xfer(1'b1, 32'h304, 3'd2); settle();
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL b2b_rd2_ready got %b exp 1", HREADYOUT); else n_pass++;
    n_checks++; if (HRDATA !== 32'h1122AA44) $display("FAIL b2b_rd2 got %h exp 1122aa44", HRDATA); else n_pass++;
    tick(); bus_idle(); HWDATA = 32'h01020304; settle();
    n_checks++; if (wea !== 4'hF) $display("FAIL b2b_wr_wea got %h exp f", wea); else n_pass++;
    n_checks++; if (addra !== 14'hC1) $display("FAIL b2b_wr_addra got %h exp c1", addra); else n_pass++;
    n_checks++; if (HRDATA !== 32'h0) $display("FAIL b2b_wr_hrdata got %h exp 0", HRDATA); else n_pass++;
    $display("back-to-back read/read/write: wea=%h addra=%h", wea, addra);
  endtask

  task automatic test_reset_mid_write();
    tick(); bus_xfer(1'b1, 32'h300, 3'd2);
    tick(); bus_idle(); HWDATA = 32'hFFFFFFFF; rsta = 1'b1; settle();
    n_checks++; if (wea !== 4'h0) $display("FAIL rmw_wea_in_rst got %h exp 0", wea); else n_pass++;
    tick(); rsta = 1'b0; settle();
    n_checks++; if (wea !== 4'h0) $display("FAIL rmw_wea_after got %h exp 0", wea); else n_pass++;
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL rmw_hreadyout got %b exp 1", HREADYOUT); else n_pass++;
    tick(); bus_xfer(1'b0, 32'h300, 3'd2);
    tick(); bus_idle(); settle();
    n_checks++; if (HRDATA !== 32'h55555555) $display("FAIL rmw_hrdata got %h exp 55555555", HRDATA); else n_pass++;
    $display("reset in write data phase: word 0x300=%h", HRDATA);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[14'hC1] = 32'hCAFEF00D;
    test_reset();
    test_unselected();
    test_word_rw();
    test_byte_half();
    test_hazard();
    test_diff_word();
    test_back_to_back();
    test_reset_mid_write();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
